fetch_queue: RTL

//  Parametrised instruction-fetch front end for the zerocpu core; successor to the single-cycle PC generator.

---
 rtl/fetch_queue.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order fetch requests with up to DEPTH outstanding, a PC/instruction
// queue toward decode, and redirect flush that discards stale in-flight responses.
module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000),
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
    logic              filled;
  } entry_t;

  entry_t            q [DEPTH];
  logic [ADDR_W-1:0] fetchPc;
  logic [PTR_W-1:0]  headPtr, tailPtr, fillPtr;
  logic [CNT_W-1:0]  allocCnt, dropCnt, filledCnt, unfilledCnt, dropNext;
  logic              reqFire, respFill, respDrop, pop;

  always_comb begin
    filledCnt = '0;
    for (int i = 0; i < DEPTH; i++) filledCnt = filledCnt + CNT_W'(q[i].filled);
  end

  assign unfilledCnt   = allocCnt - filledCnt;
  assign mem_req_valid = (allocCnt < CNT_W'(DEPTH)) && (dropCnt == '0);
  assign mem_req_addr  = fetchPc;
  assign reqFire       = mem_req_valid && mem_req_ready;
  assign respDrop      = mem_resp_valid && (dropCnt != '0);
  assign respFill      = mem_resp_valid && (dropCnt == '0);
  assign inst_valid    = q[headPtr].filled;
  assign pop           = inst_valid && inst_ready;
  assign inst_data     = inst_valid ? q[headPtr].data : '0;
  assign inst_pc       = inst_valid ? q[headPtr].pc   : '0;

  // Everything still owed by memory after this edge becomes stale on redirect; the true value never
  // exceeds DEPTH, so CNT_W-bit modular arithmetic is exact.
  assign dropNext = dropCnt + unfilledCnt + CNT_W'(reqFire) - CNT_W'(mem_resp_valid);

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      fillPtr  <= '0;
      allocCnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      fetchPc  <= rst ? RESET_PC : redirect_pc;
      dropCnt  <= rst ? '0 : dropNext;
    end else begin
      if (reqFire) begin
        q[tailPtr].pc     <= fetchPc;
        q[tailPtr].data   <= '0;
        q[tailPtr].filled <= 1'b0;
        tailPtr           <= tailPtr + PTR_W'(1);
        fetchPc           <= fetchPc + ADDR_W'(PC_STEP);
      end
      if (respDrop) dropCnt <= dropCnt - CNT_W'(1);
      if (respFill) begin
        q[fillPtr].data   <= mem_resp_data;
        q[fillPtr].filled <= 1'b1;
        fillPtr           <= fillPtr + PTR_W'(1);
      end
      // Head is always filled when popped, so it never aliases the fill or tail slot.
      if (pop) begin
        q[headPtr].filled <= 1'b0;
        headPtr           <= headPtr + PTR_W'(1);
      end
      allocCnt <= allocCnt + CNT_W'(reqFire) - CNT_W'(pop);
    end
  end

  respHasOwner: assert property (@(posedge clk) disable iff (rst)
    mem_resp_valid |-> (dropCnt != '0) || (unfilledCnt != '0));

endmodule
